// File: rtl/gear_frame.sv
// gear_frame: LSB-first IN_W -> OUT_W width-conversion gearbox with frame delimiting and zero padding.
// Optional macro GEAR_KEEP_EN adds in_nbits so the last word of a frame can carry fewer than IN_W bits.
`timescale 1ns/1ps
module gear_frame #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 20,
  parameter int BUF_W = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [IN_W-1:0]           in_data,
  input  logic                      in_valid,
  input  logic                      in_last,
  output logic                      in_ready,
`ifdef GEAR_KEEP_EN
  input  logic [$clog2(IN_W+1)-1:0] in_nbits,
`endif
  output logic [OUT_W-1:0]          out_data,
  output logic                      out_valid,
  output logic                      out_last,
  input  logic                      out_ready
);

  localparam int CW = $clog2(BUF_W + 1);
  localparam int NW = $clog2(IN_W + 1);

  localparam logic [CW-1:0] OUT_CNT  = CW'(OUT_W);
  localparam logic [CW-1:0] BUF_CNT  = CW'(BUF_W);
  localparam logic [CW-1:0] ROOM_CNT = CW'(BUF_W - IN_W);
  localparam logic [NW-1:0] FULL_NB  = NW'(IN_W);

  if (BUF_W < IN_W + OUT_W - 1) begin : g_bad_buf
    $error("gear_frame: BUF_W must be >= IN_W + OUT_W - 1");
  end

  logic [BUF_W-1:0] sbuf;
  logic [BUF_W-1:0] sbuf_nxt;
  logic [BUF_W-1:0] pop_buf;
  logic [BUF_W-1:0] word_ext;
  logic [BUF_W-1:0] above_mask;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic [CW-1:0]    pop_count;
  logic             pend;
  logic             pend_nxt;
  logic [NW-1:0]    word_bits;
  logic [IN_W-1:0]  word_mask;
  logic             pop;
  logic             push;

  assign in_ready  = !pend && (count <= ROOM_CNT);
  assign out_valid = (count >= OUT_CNT) || (pend && (count != '0));
  assign out_last  = pend && (count <= OUT_CNT);
  assign out_data  = sbuf[OUT_W-1:0];

  assign pop  = out_valid && out_ready;
  assign push = in_valid && in_ready;

`ifdef GEAR_KEEP_EN
  // A zero in_nbits on the last word means a full word.
  always_comb begin
    word_bits = FULL_NB;
    if (in_last && (in_nbits != '0)) word_bits = in_nbits;
  end
`else
  assign word_bits = FULL_NB;
`endif

  // Shifting all-ones by IN_W yields zero, so a full word gets an all-ones mask.
  assign word_mask = ~({IN_W{1'b1}} << word_bits);
  assign word_ext  = BUF_W'(in_data & word_mask);

  always_comb begin
    pop_buf   = sbuf;
    pop_count = count;
    if (pop) begin
      if (out_last) begin
        pop_buf   = '0;
        pop_count = '0;
      end else begin
        pop_buf   = sbuf >> OUT_W;
        pop_count = count - OUT_CNT;
      end
    end
  end

  // Push lands at the post-pop offset; in_ready is low while pend, so it never meets a frame-closing pop.
  always_comb begin
    sbuf_nxt  = pop_buf;
    count_nxt = pop_count;
    pend_nxt  = pend;
    if (pop && out_last) pend_nxt = 1'b0;
    if (push) begin
      sbuf_nxt  = pop_buf | (word_ext << pop_count);
      count_nxt = pop_count + CW'(word_bits);
      if (in_last) pend_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sbuf  <= '0;
      count <= '0;
      pend  <= 1'b0;
    end else begin
      sbuf  <= sbuf_nxt;
      count <= count_nxt;
      pend  <= pend_nxt;
    end
  end

  assign above_mask = {BUF_W{1'b1}} << count;

  a_count_range: assert property (@(posedge clk) disable iff (rst) count <= BUF_CNT);
  a_zero_above:  assert property (@(posedge clk) disable iff (rst) (sbuf & above_mask) == '0);

endmodule
